seq_datapath: RTL and testbench



---
 rtl/seq_datapath.sv | 188 ++++++++++++++++++
 tb/tb_seq_datapath.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// seq_datapath: responder end of the capture/op/valid strobe protocol.
// Operands A, B and C are latched from a shared bus on one-hot capture
// strobes. A result is computed on op and published on valid. Strobes that
// arrive out of order set a sticky error flag. Completed transactions are
// counted, and the count saturates at all-ones.
module seq_datapath #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [1:0]         mode,
   input  logic [2:0]         capture,
   input  logic               op,
   input  logic               valid,
   input  logic               clr_err,
   output logic [WIDTH+1:0]   result,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   txn_count
);

   localparam int RW = WIDTH + 2;

   // Each state names the strobe it accepts next: capture[0], capture[1],
   // capture[2], op, valid.
   typedef enum logic [2:0] {
      IDLE,
      GOT_A,
      GOT_B,
      GOT_C,
      COMPUTED
   } state_e;

   // One-hot strobe codes within s = {valid, op, capture[2:0]}.
   localparam logic [4:0] S_CAP_A = 5'b00001;
   localparam logic [4:0] S_CAP_B = 5'b00010;
   localparam logic [4:0] S_CAP_C = 5'b00100;
   localparam logic [4:0] S_OP    = 5'b01000;
   localparam logic [4:0] S_VALID = 5'b10000;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
   logic [1:0]        mode_q, mode_d;
   logic [RW-1:0]     acc_q, acc_d;
   logic [RW-1:0]     result_q, result_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [4:0]        strobe;
   logic              proto_err;
   logic [RW-1:0]     f_val;
   logic [WIDTH-1:0]  max_ab, max_abc, min_ab, min_abc;

   assign strobe = {valid, op, capture};

   // Operation on the latched operands. The operands are zero-extended, and
   // the result wraps modulo 2^(WIDTH+2).
   always_comb begin
      max_ab  = (a_q > b_q) ? a_q : b_q;
      max_abc = (max_ab > c_q) ? max_ab : c_q;
      min_ab  = (a_q < b_q) ? a_q : b_q;
      min_abc = (min_ab < c_q) ? min_ab : c_q;
      unique case (mode_q)
         2'b00:   f_val = RW'(a_q) + RW'(b_q) + RW'(c_q);
         2'b01:   f_val = RW'(a_q) + RW'(b_q) - RW'(c_q);
         2'b10:   f_val = RW'(max_abc);
         default: f_val = RW'(min_abc);
      endcase
   end

   // Next-state logic. Every state accepts exactly one lone strobe. Any other
   // non-zero strobe vector is a protocol error, which sends the FSM to IDLE.
   // A lone capture[0] in that case also restarts the transaction.
   always_comb begin
      // NOTE: every variable gets a default before the case, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      proto_err = 1'b0;

      if (strobe != 5'b00000) begin
         unique case (state_q)
            IDLE: begin
               if (strobe == S_CAP_A) begin
                  a_d     = data_in;
                  mode_d  = mode;
                  state_d = GOT_A;
               end else begin
                  proto_err = 1'b1;
               end
            end
            GOT_A: begin
               if (strobe == S_CAP_B) begin
                  b_d     = data_in;
                  state_d = GOT_B;
               end else begin
                  proto_err = 1'b1;
               end
            end
            GOT_B: begin
               if (strobe == S_CAP_C) begin
                  c_d     = data_in;
                  state_d = GOT_C;
               end else begin
                  proto_err = 1'b1;
               end
            end
            GOT_C: begin
               if (strobe == S_OP) begin
                  acc_d   = f_val;
                  state_d = COMPUTED;
               end else begin
                  proto_err = 1'b1;
               end
            end
            COMPUTED: begin
               if (strobe == S_VALID) begin
                  result_d = acc_q;
                  done_d   = 1'b1;
                  if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                  state_d  = IDLE;
               end else begin
                  proto_err = 1'b1;
               end
            end
            default: proto_err = 1'b1;
         endcase

         if (proto_err) begin
            state_d = IDLE;
            if (strobe == S_CAP_A) begin
               a_d     = data_in;
               mode_d  = mode;
               state_d = GOT_A;
            end
         end
      end

      // A new error wins over clr_err in the same cycle.
      err_d = (err_q & ~clr_err) | proto_err;
   end

   // State register. Reset abandons any transaction in flight and clears
   // every register, the operands included.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         mode_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // values from before the clock edge.
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         mode_q   <= mode_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result    = result_q;
   assign done      = done_q;
   assign err       = err_q;
   assign txn_count = cnt_q;

endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: directed and randomized checks of seq_datapath.
// The reference model tracks which strobe of the transaction is expected
// next, the operands accepted so far, and the published outputs.
module tb_seq_datapath;

   localparam int W     = 8;
   localparam int CW    = 8;
   localparam int RMASK = (1 << (W + 2)) - 1;
   localparam int CMAX  = (1 << CW) - 1;

   logic            clock;
   logic            rst_n;
   logic [W-1:0]    data_in;
   logic [1:0]      mode;
   logic [2:0]      capture;
   logic            op;
   logic            valid;
   logic            clr_err;
   logic [W+1:0]    result;
   logic            done;
   logic            err;
   logic [CW-1:0]   txn_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: index of the next expected strobe (0..4),
   // the operands accepted so far, and the expected outputs.
   int m_idx, m_a, m_b, m_c, m_mode, m_acc;
   int m_result, m_cnt;
   bit m_err, m_done;

   seq_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .mode      (mode),
      .capture   (capture),
      .op        (op),
      .valid     (valid),
      .clr_err   (clr_err),
      .result    (result),
      .done      (done),
      .err       (err),
      .txn_count (txn_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int f_model(input int m, input int a, input int b, input int c);
      int mx, mn;
      mx = a; if (b > mx) mx = b; if (c > mx) mx = c;
      mn = a; if (b < mn) mn = b; if (c < mn) mn = c;
      case (m)
         0:       return (a + b + c) & RMASK;
         1:       return (a + b - c) & RMASK;
         2:       return mx;
         default: return mn;
      endcase
   endfunction

   task automatic model_reset();
      m_idx = 0; m_a = 0; m_b = 0; m_c = 0; m_mode = 0; m_acc = 0;
      m_result = 0; m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
   endtask

   // Applies one cycle of strobes to the model.
   task automatic model_update(input logic [4:0] s, input int d, input int m, input bit clr);
      bit perr;
      perr   = 1'b0;
      m_done = 1'b0;
      if (s != 5'd0) begin
         if (s == (5'd1 << m_idx)) begin
            case (m_idx)
               0: begin m_a = d; m_mode = m; end
               1: m_b = d;
               2: m_c = d;
               3: m_acc = f_model(m_mode, m_a, m_b, m_c);
               default: begin
                  m_result = m_acc;
                  m_done   = 1'b1;
                  if (m_cnt < CMAX) m_cnt++;
               end
            endcase
            m_idx = (m_idx + 1) % 5;
         end else begin
            perr = 1'b1;
            if (s == 5'd1) begin m_a = d; m_mode = m; m_idx = 1; end
            else m_idx = 0;
         end
      end
      m_err = (m_err && !clr) || perr;
   endtask

   // Drives one cycle of stimulus, then checks every output against the model.
   task automatic step(input logic [4:0] s, input int d, input int m, input bit clr);
      @(negedge clock);
      {valid, op, capture} = s;
      data_in = d[W-1:0];
      mode    = m[1:0];
      clr_err = clr;
      @(posedge clock);
      #1;
      {valid, op, capture} = 5'd0;
      clr_err = 1'b0;
      model_update(s, d, m, clr);
      check("result", 32'(result), 32'(m_result));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("txn_count", 32'(txn_count), 32'(m_cnt));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(5'd0, int'($urandom_range(255)), int'($urandom_range(3)), 1'b0);
   endtask

   // Runs a complete legal transaction with 0..maxgap idle cycles before each strobe.
   task automatic txn(input int m, input int a, input int b, input int c, input int maxgap);
      int ops[3];
      ops = '{a, b, c};
      for (int k = 0; k < 5; k++) begin
         idle(int'($urandom_range(maxgap)));
         step(5'd1 << k, (k < 3) ? ops[k] : int'($urandom_range(255)), m, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      data_in = '0; mode = '0; capture = '0; op = 1'b0; valid = 1'b0; clr_err = 1'b0;
      model_reset();
      #12;
      check("reset_result", 32'(result), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_count", 32'(txn_count), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;

      // Back-to-back strobes; 200+100+50 exceeds 8 bits.
      txn(0, 200, 100, 50, 0);
      check("tp_sum", 32'(result), 32'd350);
      idle(1);
      txn(1, 5, 3, 20, 0);
      check("tp_sub_neg", 32'(result), 32'h3F4);
      txn(2, 7, 250, 9, 2);
      check("tp_max", 32'(result), 32'd250);
      txn(3, 7, 250, 9, 2);
      check("tp_min", 32'(result), 32'd7);

      // op while in GOT_A, then clr_err, then a clean transaction.
      step(5'b00001, 11, 0, 1'b0);
      step(5'b01000, 0, 0, 1'b0);
      check("op_in_got_a_err", 32'(err), 32'd1);
      check("op_in_got_a_result", 32'(result), 32'd7);
      idle(2);
      step(5'd0, 0, 0, 1'b1);
      check("clr_err", 32'(err), 32'd0);
      txn(0, 1, 2, 3, 1);
      check("after_clr", 32'(result), 32'd6);

      // Two capture bits in one cycle from IDLE.
      step(5'b00011, 99, 0, 1'b0);
      check("multi_bit_err", 32'(err), 32'd1);
      // clr_err in the same cycle as a new error: err stays set.
      step(5'b00010, 0, 0, 1'b1);
      check("clr_vs_new_err", 32'(err), 32'd1);
      step(5'd0, 0, 0, 1'b1);

      // A lone capture[0] in GOT_C restarts the transaction with the new A.
      step(5'b00001, 1, 0, 1'b0);
      step(5'b00010, 2, 0, 1'b0);
      step(5'b00100, 3, 0, 1'b0);
      step(5'b00001, 40, 0, 1'b0);
      check("restart_err", 32'(err), 32'd1);
      step(5'b00010, 50, 0, 1'b0);
      step(5'b00100, 60, 0, 1'b0);
      step(5'b01000, 0, 0, 1'b0);
      step(5'b10000, 0, 0, 1'b0);
      check("restart_result", 32'(result), 32'd150);
      step(5'd0, 0, 0, 1'b1);

      // Synchronous-point reset, then 300 random legal transactions.
      @(negedge clock);
      rst_n = 1'b0;
      model_reset();
      @(negedge clock);
      rst_n = 1'b1;
      for (int t = 0; t < 300; t++)
         txn(int'($urandom_range(3)), int'($urandom_range(255)), int'($urandom_range(255)),
             int'($urandom_range(255)), 5);
      check("count_saturated", 32'(txn_count), 32'd255);

      // Asynchronous reset in the middle of a clock period while in GOT_C.
      step(5'b00001, 10, 0, 1'b0);
      step(5'b00010, 20, 0, 1'b0);
      step(5'b00100, 30, 0, 1'b0);
      @(posedge clock);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_result", 32'(result), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_err", 32'(err), 32'd0);
      check("async_rst_count", 32'(txn_count), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;
      txn(1, 100, 40, 30, 3);
      check("post_reset_result", 32'(result), 32'd110);
      check("post_reset_count", 32'(txn_count), 32'd1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
